// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the buffered UART transmitter: the transmit FSM state
// type, the parity-type encodings carried with each frame, and the legal
// ranges for the transmitter parameters.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_WIDTH_MIN   = 5;
  localparam int DATA_WIDTH_MAX   = 9;
  localparam int FIFO_DEPTH_MIN   = 2;
  localparam int CLKS_PER_BIT_MIN = 1;
  localparam int STOP_BITS_MIN    = 1;
  localparam int STOP_BITS_MAX    = 2;

endpackage

// File: rtl/uart_tx_gen2_if.sv
// -----------------------------------------------------------------------------
// uart_tx_gen2_if
// Bundles the enqueue side and the line/status side of the UART transmitter.
//   P_DATA      payload to enqueue
//   PAR_EN      parity bit enabled for this frame
//   PAR_TYP     0 = even parity, 1 = odd parity
//   DATA_VALID  enqueue request
//   TX_OUT      serial line, idle high
//   Busy        a frame is on the line
//   FIFO_FULL   frame buffer full
//   FIFO_EMPTY  frame buffer empty
// master: the producer of frames; slave: the transmitter.
// -----------------------------------------------------------------------------
interface uart_tx_gen2_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  DATA_VALID;
  logic                  TX_OUT;
  logic                  Busy;
  logic                  FIFO_FULL;
  logic                  FIFO_EMPTY;

  modport master (
    output P_DATA, PAR_EN, PAR_TYP, DATA_VALID,
    input  TX_OUT, Busy, FIFO_FULL, FIFO_EMPTY
  );

  modport slave (
    input  P_DATA, PAR_EN, PAR_TYP, DATA_VALID,
    output TX_OUT, Busy, FIFO_FULL, FIFO_EMPTY
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Small frame buffer for the UART transmitter with registered full/empty flags.
//   clk, reset  clock and asynchronous active-high reset
//   wr_en       write request (ignored when full unless a read happens too)
//   wr_data     entry to store
//   rd_en       read request (ignored when empty)
//   rd_data     head entry, valid whenever empty is low
//   full        DEPTH entries held
//   empty       no entries held
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_rd;
  logic             do_wr;

  // A write into a full buffer is still taken when the head leaves on the
  // same edge, so the occupancy stays put instead of losing the entry.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Next occupancy, used both for the counter and for the registered flags.
  always_comb begin
    count_next = count;
    if (do_wr && !do_rd) begin
      count_next = count + 1'b1;
    end else if (!do_wr && do_rd) begin
      count_next = count - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage carries no reset; stale entries are never visible through the
  // empty flag.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_gen2.sv
// -----------------------------------------------------------------------------
// uart_tx_gen2
// Buffered UART transmitter. Frames {PAR_TYP, PAR_EN, P_DATA} are queued in a
// small FIFO and sent as start bit, payload LSB first, optional parity bit and
// STOP_BITS stop bits, each bit lasting CLKS_PER_BIT clocks. Queued frames are
// sent back-to-back without an idle gap.
//   clk    single clock, rising edge
//   reset  asynchronous active-high reset, aborts any frame in progress
//   bus    uart_tx_gen2_if slave: enqueue inputs, TX_OUT/Busy/FIFO flags
// -----------------------------------------------------------------------------
module uart_tx_gen2
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_gen2_if.slave bus
);

  localparam int ENTRY_W = DATA_WIDTH + 2;
  localparam int BIT_W   = $clog2(DATA_WIDTH);
  localparam int BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_data_width
    $error("uart_tx_gen2: DATA_WIDTH must be within 5..9");
  end
  if (FIFO_DEPTH < FIFO_DEPTH_MIN || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_gen2: FIFO_DEPTH must be a power of two and at least 2");
  end
  if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_clks_per_bit
    $error("uart_tx_gen2: CLKS_PER_BIT must be at least 1");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_tx_gen2: STOP_BITS must be 1 or 2");
  end

  tx_state_e             state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  pop;
  logic                  baud_last;
  logic [ENTRY_W-1:0]    entry_in;
  logic [ENTRY_W-1:0]    head;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_pen;
  logic                  head_ptyp;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign entry_in  = {bus.PAR_TYP, bus.PAR_EN, bus.P_DATA};
  assign head_data = head[DATA_WIDTH-1:0];
  assign head_pen  = head[DATA_WIDTH];
  assign head_ptyp = head[DATA_WIDTH+1];

  uart_tx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.DATA_VALID),
    .wr_data (entry_in),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign baud_last = (baud_q == BAUD_LAST);

  // Next-state logic. bit_q counts payload bits in DATA and stop bits in STOP.
  // A pop from IDLE or from the end of the last stop bit loads the next frame
  // and goes straight to START.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_last ? '0 : baud_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        pop    = !fifo_empty;
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (baud_last) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_last) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (baud_last) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = IDLE;
            pop     = !fifo_empty;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pop) begin
      state_d   = START;
      baud_d    = '0;
      shift_d   = head_data;
      par_en_d  = head_pen;
      par_bit_d = (^head_data) ^ (head_ptyp == PAR_ODD);
    end

    // The line level is computed from the next state so TX_OUT is a register
    // that lines up exactly with the state it belongs to.
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // State, counters, shift register and the registered serial line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
    end
  end

  assign bus.TX_OUT     = tx_q;
  assign bus.Busy       = (state_q != IDLE);
  assign bus.FIFO_FULL  = fifo_full;
  assign bus.FIFO_EMPTY = fifo_empty;

endmodule

// File: tb/tb_uart_tx_gen2.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_gen2
// Four transmitter configurations side by side:
//   0: defaults (8 data bits, depth 4, 1 clk/bit, 1 stop bit)
//   1: 8 data bits, depth 4, 4 clks/bit, 2 stop bits
//   2: 9 data bits, depth 4, 1 clk/bit, 1 stop bit
//   3: 5 data bits, depth 2, 1 clk/bit, 1 stop bit
// Each configuration has a model that expands every accepted frame into the
// list of line levels it must produce, cycle by cycle, and a compare process
// that checks TX_OUT, Busy and the FIFO flags against it on every cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx_gen2;

  logic clk;
  logic reset;

  logic [8:0] d_data [4];
  logic       d_pen  [4];
  logic       d_ptyp [4];
  logic       d_dv   [4];

  logic tx_o    [4];
  logic busy_o  [4];
  logic full_o  [4];
  logic empty_o [4];

  int errors = 0;
  int checks = 0;
  int exp_seq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports it when it does not hold.
  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Presents one enqueue request for the next rising edge; call at a negedge.
  task automatic applyStimulus(input int idx, input int data, input bit pen, input bit ptyp);
    d_data[idx] = 9'(data);
    d_pen[idx]  = pen;
    d_ptyp[idx] = ptyp;
    d_dv[idx]   = 1'b1;
    @(negedge clk);
    d_dv[idx]   = 1'b0;
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int DW  = (g == 2) ? 9 : (g == 3) ? 5 : 8;
    localparam int FD  = (g == 3) ? 2 : 4;
    localparam int CPB = (g == 1) ? 4 : 1;
    localparam int SB  = (g == 1) ? 2 : 1;

    uart_tx_gen2_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_gen2 #(
      .DATA_WIDTH   (DW),
      .FIFO_DEPTH   (FD),
      .CLKS_PER_BIT (CPB),
      .STOP_BITS    (SB)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    assign bus.P_DATA     = d_data[g][DW-1:0];
    assign bus.PAR_EN     = d_pen[g];
    assign bus.PAR_TYP    = d_ptyp[g];
    assign bus.DATA_VALID = d_dv[g];
    assign tx_o[g]        = bus.TX_OUT;
    assign busy_o[g]      = bus.Busy;
    assign full_o[g]      = bus.FIFO_FULL;
    assign empty_o[g]     = bus.FIFO_EMPTY;

    int fifo_model[$];
    int line_model[$];

    // Model: line_model[0] is the level expected on the line this cycle.
    // A new frame is taken when the line is idle or in its final cycle.
    always @(posedge clk or posedge reset) begin : model
      int  sz;
      int  ent;
      int  pay;
      int  par;
      bit  do_pop;
      if (reset) begin
        fifo_model.delete();
        line_model.delete();
      end else begin
        sz     = fifo_model.size();
        do_pop = (sz > 0) && (line_model.size() <= 1);
        if (line_model.size() > 0) begin
          void'(line_model.pop_front());
        end
        if (do_pop) begin
          ent = fifo_model.pop_front();
          pay = ent & ((1 << DW) - 1);
          for (int c = 0; c < CPB; c++) line_model.push_back(0);
          for (int i = 0; i < DW; i++) begin
            for (int c = 0; c < CPB; c++) line_model.push_back((pay >> i) & 1);
          end
          if (((ent >> DW) & 1) == 1) begin
            par = (ent >> (DW + 1)) & 1;
            for (int i = 0; i < DW; i++) par = par ^ ((pay >> i) & 1);
            for (int c = 0; c < CPB; c++) line_model.push_back(par);
          end
          for (int c = 0; c < SB * CPB; c++) line_model.push_back(1);
        end
        if (d_dv[g] && (sz < FD || do_pop)) begin
          ent = int'(d_data[g]) & ((1 << DW) - 1);
          if (d_pen[g])  ent = ent | (1 << DW);
          if (d_ptyp[g]) ent = ent | (1 << (DW + 1));
          fifo_model.push_back(ent);
        end
      end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin : compare
      checkOutput($sformatf("cfg%0d TX_OUT", g), int'(bus.TX_OUT),
                  (line_model.size() > 0) ? line_model[0] : 1);
      checkOutput($sformatf("cfg%0d Busy", g), int'(bus.Busy),
                  int'(line_model.size() > 0));
      checkOutput($sformatf("cfg%0d FIFO_FULL", g), int'(bus.FIFO_FULL),
                  int'(fifo_model.size() == FD));
      checkOutput($sformatf("cfg%0d FIFO_EMPTY", g), int'(bus.FIFO_EMPTY),
                  int'(fifo_model.size() == 0));
    end
  end

  // Sends one frame into an idle transmitter and checks it against exp_seq,
  // one entry per bit, each bit held cpb cycles.
  task automatic literalFrame(input string name, input int idx, input int data,
                              input bit pen, input bit ptyp, input int cpb, input int cyc);
    int busy_cnt;
    busy_cnt = 0;
    applyStimulus(idx, data, pen, ptyp);
    checkOutput({name, " TX before start"}, int'(tx_o[idx]), 1);
    for (int k = 0; k < cyc; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s cycle%0d", name, k), int'(tx_o[idx]), exp_seq[k / cpb]);
      if (busy_o[idx]) busy_cnt++;
    end
    @(negedge clk);
    checkOutput({name, " busy cycles"}, busy_cnt, cyc);
    checkOutput({name, " idle after frame"}, int'(busy_o[idx]), 0);
  endtask

  // Sends every payload value with odd parity, then lets the line drain.
  task automatic exhaustive(input int idx, input int dw);
    int wait_cnt;
    for (int v = 0; v < (1 << dw); v++) begin
      wait_cnt = 0;
      while (full_o[idx] && wait_cnt < 100) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (wait_cnt >= 100) begin
        checkOutput($sformatf("cfg%0d full wait in time", idx), 0, 1);
      end
      applyStimulus(idx, v, 1'b1, 1'b1);
    end
    wait_cnt = 0;
    while ((busy_o[idx] || !empty_o[idx]) && wait_cnt < 1000) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput($sformatf("cfg%0d drained in time", idx), int'(wait_cnt < 1000), 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int busy_cnt;
    int first_empty;

    for (int i = 0; i < 4; i++) begin
      d_data[i] = '0;
      d_pen[i]  = 1'b0;
      d_ptyp[i] = 1'b0;
      d_dv[i]   = 1'b0;
    end
    reset = 1'b0;
    #1 reset = 1'b1;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("cfg%0d reset TX_OUT", i), int'(tx_o[i]), 1);
      checkOutput($sformatf("cfg%0d reset Busy", i), int'(busy_o[i]), 0);
      checkOutput($sformatf("cfg%0d reset FIFO_EMPTY", i), int'(empty_o[i]), 1);
      checkOutput($sformatf("cfg%0d reset FIFO_FULL", i), int'(full_o[i]), 0);
    end

    // Release at a negedge; the first enqueue lands on the very next edge.
    reset = 1'b0;
    $display("[TB] frame shape checks");
    exp_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    literalFrame("A5 even", 0, 'hA5, 1'b1, 1'b0, 1, 11);
    exp_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
    literalFrame("A5 odd", 0, 'hA5, 1'b1, 1'b1, 1, 11);
    exp_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    literalFrame("A5 no parity", 0, 'hA5, 1'b0, 1'b0, 1, 10);
    exp_seq = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1};
    literalFrame("3C 4clk 2stop", 1, 'h3C, 1'b1, 1'b0, 4, 48);

    // Burst of six into a depth-4 buffer: five kept, the sixth dropped, then
    // one more pushed on the edge where the full buffer pops.
    $display("[TB] burst and full-buffer checks");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 'h10 + i, 1'b1, i[0]);
      if (i == 4) checkOutput("burst full after 5th", int'(full_o[0]), 1);
    end
    checkOutput("burst full after 6th", int'(full_o[0]), 1);
    repeat (6) @(negedge clk);
    applyStimulus(0, 'h99, 1'b1, 1'b0);
    checkOutput("full kept on push+pop", int'(full_o[0]), 1);
    busy_cnt    = 0;
    first_empty = -1;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (!busy_o[0]) break;
      busy_cnt++;
      if (first_empty < 0 && empty_o[0]) first_empty = j;
    end
    checkOutput("burst busy run", busy_cnt, 54);
    checkOutput("burst empty at last pop", first_empty, 43);

    // Reset in the middle of payload bit 3 with two frames still queued.
    $display("[TB] mid-frame reset checks");
    applyStimulus(0, 'hA5, 1'b1, 1'b0);
    applyStimulus(0, 'h5A, 1'b1, 1'b0);
    applyStimulus(0, 'hC3, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("pre-reset bit3 TX_OUT", int'(tx_o[0]), 0);
    checkOutput("pre-reset FIFO_EMPTY", int'(empty_o[0]), 0);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset TX_OUT", int'(tx_o[0]), 1);
    checkOutput("async reset Busy", int'(busy_o[0]), 0);
    checkOutput("async reset FIFO_EMPTY", int'(empty_o[0]), 1);
    @(negedge clk);
    reset = 1'b0;
    busy_cnt = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (busy_o[0]) busy_cnt++;
    end
    checkOutput("no frame after reset", busy_cnt, 0);

    $display("[TB] exhaustive odd-parity payloads");
    exhaustive(2, 9);
    exhaustive(3, 5);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_gen2.md
UART_TX_GEN2 -- requirements
Module: uart_tx_gen2

Interface
REQ-001 Parameter DATA_WIDTH, default 8: payload bits per frame; legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 4: frame-buffer entries; power of two, at least 2.
REQ-003 Parameter CLKS_PER_BIT, default 1: clk cycles per serial bit; at least 1.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-005 clk  input  1: single clock, all state on rising edge.
REQ-006 reset  input  1: asynchronous, active-high reset.
REQ-007 P_DATA  input  DATA_WIDTH: payload to enqueue.
REQ-008 PAR_EN  input  1: parity bit enabled for this frame.
REQ-009 PAR_TYP  input  1: 0 = even parity, 1 = odd parity.
REQ-010 DATA_VALID  input  1: enqueue request.
REQ-011 TX_OUT  output  1: registered serial line, idle high.
REQ-012 Busy  output  1: high while a frame is on the line.
REQ-013 FIFO_FULL  output  1: buffer holds FIFO_DEPTH entries.
REQ-014 FIFO_EMPTY  output  1: buffer holds 0 entries.

Function
REQ-015 Enqueue: DATA_VALID high and FIFO_FULL low at a rising edge stores {PAR_TYP, PAR_EN, P_DATA} as one entry; parity settings are per frame.
REQ-016 DATA_VALID while FIFO_FULL is high is dropped silently; the buffer contents are unchanged.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE with buffer non-empty: pop the head entry at the edge and enter START.
REQ-019 Simultaneous enqueue and pop on a full buffer: both occur and the count is unchanged; on an empty buffer no pop occurs.
REQ-020 START drives TX_OUT=0.
REQ-021 DATA drives payload bits LSB first, DATA_WIDTH bits, using a bit counter of width clog2(DATA_WIDTH).
REQ-022 PARITY is entered only if the popped PAR_EN=1; parity bit = XOR of the payload, XORed with PAR_TYP; otherwise DATA goes directly to STOP.
REQ-023 STOP drives TX_OUT=1 for STOP_BITS bit periods.
REQ-024 Every bit, including each stop bit, lasts exactly CLKS_PER_BIT cycles, timed by a baud counter that wraps at CLKS_PER_BIT-1.
REQ-025 End of the last stop bit: buffer non-empty goes directly to START (no idle gap, pop on that edge); otherwise go to IDLE.
REQ-026 Busy is high in every state except IDLE; TX_OUT=1 in IDLE.
REQ-027 Latency: first start bit appears on TX_OUT the cycle after the edge that pops from IDLE; an enqueue into an empty buffer in IDLE gives start on TX_OUT 2 cycles after the DATA_VALID edge.
REQ-028 Frame length = (1 + DATA_WIDTH + PAR_EN + STOP_BITS) * CLKS_PER_BIT cycles.
REQ-029 FIFO pointers wrap modulo FIFO_DEPTH; the occupancy count is clog2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-030 While reset is asserted: state=IDLE, TX_OUT=1, Busy=0, FIFO_EMPTY=1, FIFO_FULL=0, all counters and pointers 0.
REQ-031 Reset mid-frame aborts immediately; TX_OUT returns high asynchronously and buffered entries are discarded.
REQ-032 The first enqueue is accepted at the first rising edge after reset deasserts.

Structure
REQ-033 Package uart_tx_pkg holds the state enum typedef, parity type constants (PAR_EVEN=0, PAR_ODD=1) and the legal parameter ranges.
REQ-034 The FIFO is a sub-module uart_tx_fifo (parametrised width and depth, registered flags); the FSM, shift register and counters stay in uart_tx_gen2.
REQ-035 Illegal parameter values raise an elaboration-time error.

Verification
REQ-036 Defaults; enqueue P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 (11 cycles), Busy high for 11 cycles.
REQ-037 Same data with PAR_TYP=1 -> parity bit 1; PAR_EN=0 -> 10-bit frame with no parity bit.
REQ-038 CLKS_PER_BIT=4, STOP_BITS=2, PAR_EN=1; enqueue 0x3C -> 48-cycle frame, each bit held 4 cycles, parity bit 0.
REQ-039 FIFO_DEPTH=4; enqueue 6 bytes on consecutive cycles while idle -> FIFO_FULL asserts, the 6th byte is dropped, 5 frames are sent back-to-back with no idle gap, FIFO_EMPTY rises at the last pop.
REQ-040 Assert reset in the DATA state at bit 3 -> TX_OUT=1, Busy=0 and FIFO_EMPTY=1 without waiting for a clock edge; no frame resumes after release.
REQ-041 DATA_WIDTH=9 and DATA_WIDTH=5 with odd parity -> correct bit count and parity on all 2^N payload values (exhaustive).
